costas_loop_filter: RTL and testbench

//  Closes the Costas loop downstream of the I/Q arm low-pass filters. Each valid I/Q pair

---
 rtl/costas_pkg.sv | 17 +
 rtl/costas_pi_filter.sv | 92 +++++++++
 rtl/costas_loop_filter.sv | 144 ++++++++++++++
 tb/tb_costas_loop_filter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/costas_pkg.sv
// Shared constants for the Costas loop filter: write-FSM encoding,
// nominal NCO frequency word and NCO register-select codes.
package costas_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      WRITE = 2'd2,
      GAP   = 2'd3
   } wr_state_t;

   localparam logic [31:0] FREQ_INIT = 32'h2000_0000;

   localparam logic REG_FREQ  = 1'b0;
   localparam logic REG_PHASE = 1'b1;

endpackage

// File: rtl/costas_pi_filter.sv
// Phase detector plus PI loop filter.
// Stage 1 registers e = sign(I)*Q (top ERR_W bits of Q, saturating negate).
// Stage 2 updates the clamped integrator and the NCO frequency word.
module costas_pi_filter
   import costas_pkg::*;
#(
   parameter int          IN_W    = 26,
   parameter int          ERR_W   = 16,
   parameter int          KP_SHL  = 8,
   parameter int          KI_SHL  = 2,
   parameter logic [31:0] INT_LIM = 32'h0800_0000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic signed [IN_W-1:0]  i_din,
   input  logic signed [IN_W-1:0]  q_din,
   input  logic                    din_valid,
   output logic signed [ERR_W-1:0] phase_err,
   output logic                    err_valid,
   output logic [31:0]             freq_word
);

   localparam logic signed [ERR_W-1:0] ERR_MAX = {1'b0, {(ERR_W-1){1'b1}}};
   localparam logic signed [ERR_W-1:0] ERR_MIN = {1'b1, {(ERR_W-1){1'b0}}};
   localparam logic signed [32:0]      LIM_POS = $signed({1'b0, INT_LIM});
   localparam logic signed [32:0]      LIM_NEG = -LIM_POS;

   logic signed [ERR_W-1:0] qs;
   logic signed [ERR_W-1:0] err_next;
   logic signed [31:0]      integ_reg;
   logic signed [31:0]      integ_next;
   logic signed [31:0]      e_ext;
   logic signed [31:0]      int_step;
   logic signed [31:0]      prop_term;
   logic signed [32:0]      integ_sum;
   logic [31:0]             freq_next;
   logic                    unused_bits;

   // Only the sign of I and the top ERR_W bits of Q take part in the error.
   assign unused_bits = ^{i_din[IN_W-2:0], q_din[IN_W-ERR_W-1:0]};

   // Phase detector: negate Q when I is negative, saturating the one overflow case.
   always_comb begin
      qs       = q_din[IN_W-1 -: ERR_W];
      err_next = qs;
      if (i_din[IN_W-1]) begin
         err_next = (qs == ERR_MIN) ? ERR_MAX : -qs;
      end
   end

   // Stage 1 register: error and its one-cycle-delayed valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_err <= '0;
         err_valid <= 1'b0;
      end else begin
         err_valid <= din_valid;
         if (din_valid) begin
            phase_err <= err_next;
         end
      end
   end

   // Loop arithmetic: integrator step, clamp, proportional path and frequency sum.
   always_comb begin
      e_ext     = {{(32-ERR_W){phase_err[ERR_W-1]}}, phase_err};
      int_step  = e_ext <<< KI_SHL;
      prop_term = e_ext <<< KP_SHL;
      integ_sum = {integ_reg[31], integ_reg} + {int_step[31], int_step};
      if (integ_sum > LIM_POS) begin
         integ_next = LIM_POS[31:0];
      end else if (integ_sum < LIM_NEG) begin
         integ_next = LIM_NEG[31:0];
      end else begin
         integ_next = integ_sum[31:0];
      end
      freq_next = FREQ_INIT + integ_next + prop_term;
   end

   // Stage 2 register: integrator and frequency word advance only while enabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         integ_reg <= '0;
         freq_word <= FREQ_INIT;
      end else if (err_valid && enable) begin
         integ_reg <= integ_next;
         freq_word <= freq_next;
      end
   end

endmodule

// File: rtl/costas_loop_filter.sv
// Costas loop closure: PI filter, periodic NCO frequency-register writes
// (one write per UPDATE_DIV samples, with a mandatory gap cycle) and lock detect.
module costas_loop_filter
   import costas_pkg::*;
#(
   parameter int               IN_W       = 26,
   parameter int               ERR_W      = 16,
   parameter int               KP_SHL     = 8,
   parameter int               KI_SHL     = 2,
   parameter logic [31:0]      INT_LIM    = 32'h0800_0000,
   parameter int               UPDATE_DIV = 16,
   parameter logic [ERR_W-1:0] LOCK_TH    = 16'd512,
   parameter int               LOCK_CNT   = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic signed [IN_W-1:0]  i_din,
   input  logic signed [IN_W-1:0]  q_din,
   input  logic                    din_valid,
   output logic                    nco_we,
   output logic                    nco_reg_se,
   output logic [31:0]             nco_data,
   output logic [31:0]             freq_word,
   output logic signed [ERR_W-1:0] phase_err,
   output logic                    lock
);

   localparam int CNT_W = $clog2(UPDATE_DIV);
   localparam int RUN_W = $clog2(LOCK_CNT + 1);

   wr_state_t        state_reg;
   wr_state_t        state_next;
   logic [CNT_W-1:0] cnt_reg;
   logic             req_reg;
   logic             req_clear;
   logic [31:0]      data_reg;
   logic [RUN_W-1:0] run_reg;
   logic [ERR_W-1:0] err_mag;
   logic             err_valid;
   logic             sample_en;
   logic             wrap;

   costas_pi_filter #(
      .IN_W    (IN_W),
      .ERR_W   (ERR_W),
      .KP_SHL  (KP_SHL),
      .KI_SHL  (KI_SHL),
      .INT_LIM (INT_LIM)
   ) u_pi (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .i_din     (i_din),
      .q_din     (q_din),
      .din_valid (din_valid),
      .phase_err (phase_err),
      .err_valid (err_valid),
      .freq_word (freq_word)
   );

   assign sample_en  = err_valid & enable;
   assign wrap       = sample_en && (cnt_reg == CNT_W'(UPDATE_DIV - 1));
   assign nco_reg_se = REG_FREQ;

   // Sample counter and single-deep update request (a new wrap wins over a clear).
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg <= '0;
         req_reg <= 1'b0;
      end else begin
         if (sample_en) begin
            cnt_reg <= wrap ? '0 : cnt_reg + 1'b1;
         end
         if (wrap) begin
            req_reg <= 1'b1;
         end else if (req_clear) begin
            req_reg <= 1'b0;
         end
      end
   end

   // Write FSM state register and last-written data hold register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         data_reg  <= FREQ_INIT;
      end else begin
         state_reg <= state_next;
         if (state_reg == WRITE) begin
            data_reg <= freq_word;
         end
      end
   end

   // Write FSM next state and NCO port outputs.
   always_comb begin
      state_next = state_reg;
      req_clear  = 1'b0;
      nco_we     = 1'b0;
      nco_data   = data_reg;
      case (state_reg)
         IDLE: begin
            if (enable) state_next = WAIT;
         end
         WAIT: begin
            if (!enable) begin
               state_next = IDLE;
            end else if (req_reg) begin
               state_next = WRITE;
               req_clear  = 1'b1;
            end
         end
         WRITE: begin
            nco_we     = 1'b1;
            nco_data   = freq_word;
            state_next = GAP;
         end
         GAP: begin
            state_next = enable ? WAIT : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Magnitude of the error; -2^(ERR_W-1) maps to 2^(ERR_W-1) as unsigned.
   assign err_mag = phase_err[ERR_W-1] ? -phase_err : phase_err;

   // Lock detector: run length of small-error samples, saturating at LOCK_CNT.
   always_ff @(posedge clk) begin
      if (rst) begin
         run_reg <= '0;
      end else if (sample_en) begin
         if (err_mag < LOCK_TH) begin
            if (run_reg != RUN_W'(LOCK_CNT)) run_reg <= run_reg + 1'b1;
         end else begin
            run_reg <= '0;
         end
      end
   end

   assign lock = enable && (run_reg == RUN_W'(LOCK_CNT));

endmodule

// File: tb/tb_costas_loop_filter.sv
// Directed bench for costas_loop_filter: single-sample vector table for the
// phase detector / PI arithmetic, plus sequences for writes, clamp, lock and reset.
module tb_costas_loop_filter;
   import costas_pkg::*;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               enable = 1'b0;
   logic signed [25:0] i_din = '0;
   logic signed [25:0] q_din = '0;
   logic               din_valid = 1'b0;
   logic               nco_we;
   logic               nco_reg_se;
   logic [31:0]        nco_data;
   logic [31:0]        freq_word;
   logic signed [15:0] phase_err;
   logic               lock;

   int checks = 0;
   int passed = 0;

   costas_loop_filter dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .i_din      (i_din),
      .q_din      (q_din),
      .din_valid  (din_valid),
      .nco_we     (nco_we),
      .nco_reg_se (nco_reg_se),
      .nco_data   (nco_data),
      .freq_word  (freq_word),
      .phase_err  (phase_err),
      .lock       (lock)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic signed [25:0] i;
      logic [25:0]        q;
      logic signed [15:0] perr;
      logic [31:0]        freq;
   } vec_t;

   vec_t vecs[7];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      enable = 1'b0;
      din_valid = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic wait_we(input int budget, output bit seen);
      seen = 1'b0;
      for (int n = 0; n < budget; n++) begin
         step();
         if (nco_we) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      bit          seen;
      int          pulses;
      int          last;
      logic [31:0] held;

      // e = sign(I)*q[25:10]; integ = e<<2; freq = 0x2000_0000 + integ + (e<<8)
      vecs[0] = '{ 26'sd1,  26'h0010000,  16'sd64,    32'h2000_4100 };
      vecs[1] = '{ -26'sd1, 26'h0010000,  -16'sd64,   32'h1FFF_BF00 };
      vecs[2] = '{ 26'sd1,  26'h0100000,  16'sd1024,  32'h2004_1000 };
      vecs[3] = '{ 26'sd5,  26'h2000000,  -16'sd32768, 32'h1F7E_0000 };
      vecs[4] = '{ -26'sd5, 26'h2000000,  16'sd32767, 32'h2081_FEFC };
      vecs[5] = '{ 26'sd0,  26'h3FFFC00,  -16'sd1,    32'h1FFF_FEFC };
      vecs[6] = '{ -26'sd1, 26'h3FFFFFF,  16'sd1,     32'h2000_0104 };

      // Reset state
      do_reset();
      check("rst_nco_we", 32'(nco_we), 32'd0);
      check("rst_reg_se", 32'(nco_reg_se), 32'd0);
      check("rst_nco_data", nco_data, 32'h2000_0000);
      check("rst_freq", freq_word, 32'h2000_0000);
      check("rst_perr", 32'(phase_err), 32'd0);
      check("rst_lock", 32'(lock), 32'd0);

      // Single-sample vectors
      foreach (vecs[k]) begin
         do_reset();
         enable = 1'b1;
         i_din = vecs[k].i;
         q_din = vecs[k].q;
         din_valid = 1'b1;
         step();
         din_valid = 1'b0;
         check($sformatf("vec%0d_perr", k), 32'(phase_err), 32'(vecs[k].perr));
         step();
         check($sformatf("vec%0d_freq", k), freq_word, vecs[k].freq);
         $display("vec %0d i=%0d q=%h phase_err=%0d freq_word=%h", k, vecs[k].i, vecs[k].q, phase_err, freq_word);
      end

      // Zero error: periodic writes of the nominal word every 16 samples
      do_reset();
      enable = 1'b1;
      i_din = 26'sd1000;
      q_din = '0;
      din_valid = 1'b1;
      pulses = 0;
      last = 0;
      for (int n = 1; n <= 90; n++) begin
         step();
         if (nco_we) begin
            if (pulses == 0) check("first_write_cycle", 32'(n), 32'd18);
            else check("write_spacing", 32'(n - last), 32'd16);
            check("write_data", nco_data, 32'h2000_0000);
            check("write_reg_se", 32'(nco_reg_se), 32'd0);
            pulses++;
            last = n;
         end
      end
      check("write_count", 32'(pulses), 32'd5);
      check("zero_err_freq", freq_word, 32'h2000_0000);
      $display("zero-error run: %0d writes, freq_word=%h", pulses, freq_word);

      // Integrator clamp, positive then negative
      do_reset();
      enable = 1'b1;
      i_din = 26'sd1;
      q_din = 26'h1FFFFFF;
      din_valid = 1'b1;
      for (int n = 0; n < 1100; n++) step();
      check("clamp_pos", freq_word, 32'h287F_FF00);
      for (int n = 0; n < 5; n++) step();
      check("clamp_pos_hold", freq_word, 32'h287F_FF00);
      q_din = 26'h2000000;
      for (int n = 0; n < 2200; n++) step();
      check("clamp_neg", freq_word, 32'h1780_0000);
      $display("clamp run: freq_word=%h", freq_word);

      // Enable dropped during a write
      do_reset();
      enable = 1'b1;
      i_din = 26'sd1;
      q_din = 26'h0010000;
      din_valid = 1'b1;
      wait_we(40, seen);
      check("dis_write_seen", 32'(seen), 32'd1);
      check("dis_write_data", nco_data, freq_word);
      held = freq_word;
      enable = 1'b0;
      step();
      check("dis_we_one_cycle", 32'(nco_we), 32'd0);
      check("dis_data_hold", nco_data, held);
      held = freq_word;
      pulses = 0;
      for (int n = 0; n < 50; n++) begin
         step();
         if (nco_we) pulses++;
      end
      check("dis_no_writes", 32'(pulses), 32'd0);
      check("dis_freq_frozen", freq_word, held);
      $display("disable run: freq_word=%h nco_data=%h", freq_word, nco_data);

      // Lock: 64 samples of |e|=100, then one |e|=600
      do_reset();
      enable = 1'b1;
      i_din = -26'sd1;
      q_din = 26'h0019000;
      din_valid = 1'b1;
      for (int n = 0; n < 64; n++) step();
      check("lock_before", 32'(lock), 32'd0);
      step();
      check("lock_rise", 32'(lock), 32'd1);
      i_din = 26'sd1;
      q_din = 26'h0096000;
      step();
      check("lock_hold", 32'(lock), 32'd1);
      q_din = 26'h0019000;
      step();
      check("lock_drop", 32'(lock), 32'd0);
      for (int n = 0; n < 70; n++) step();
      check("lock_regain", 32'(lock), 32'd1);
      enable = 1'b0;
      #1;
      check("lock_disabled", 32'(lock), 32'd0);
      $display("lock run: lock=%0d", lock);

      // Reset during a write
      do_reset();
      enable = 1'b1;
      i_din = 26'sd1;
      q_din = 26'h0010000;
      din_valid = 1'b1;
      wait_we(40, seen);
      check("rstw_write_seen", 32'(seen), 32'd1);
      rst = 1'b1;
      step();
      check("rstw_nco_we", 32'(nco_we), 32'd0);
      check("rstw_freq", freq_word, 32'h2000_0000);
      check("rstw_lock", 32'(lock), 32'd0);
      check("rstw_nco_data", nco_data, 32'h2000_0000);
      rst = 1'b0;
      $display("reset-in-write: nco_we=%0d freq_word=%h", nco_we, freq_word);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
